// File: rtl/median_window_gen.sv
// Raster-to-3x3 window generator feeding the median filter; window pulse one cycle after the producing pixel.
// Optional frame_done output guarded by MEDIAN_WINGEN_FRAME_DONE_EN; pix_rdy drops for WIN_GAP-1 cycles after each window.
module median_window_gen #(
  parameter int DATA_W  = 16,
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int WIN_GAP = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_vld,
  input  logic              pix_sof,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_rdy,
  output logic              win_gen_flag,
  output logic [DATA_W-1:0] data_in0,
  output logic [DATA_W-1:0] data_in1,
  output logic [DATA_W-1:0] data_in2,
  output logic [DATA_W-1:0] data_in3,
  output logic [DATA_W-1:0] data_in4,
  output logic [DATA_W-1:0] data_in5,
  output logic [DATA_W-1:0] data_in6,
  output logic [DATA_W-1:0] data_in7,
  output logic [DATA_W-1:0] data_in8
`ifdef MEDIAN_WINGEN_FRAME_DONE_EN
  ,
  output logic              frame_done
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = $clog2(WIN_GAP) + 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(WIN_GAP - 1);

  typedef enum logic {IDLE, GAP} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     gap_cnt, gap_cnt_nxt;
  logic [CW-1:0]     col, col_eff, col_nxt;
  logic [RW-1:0]     row, row_eff, row_nxt;
  logic              accept, win_hit;
  logic [DATA_W-1:0] top, mid;
  logic [DATA_W-1:0] line1 [IMG_W];
  logic [DATA_W-1:0] line2 [IMG_W];
  logic [DATA_W-1:0] win   [9];
  logic [DATA_W-1:0] dout  [9];

  assign accept  = pix_vld & pix_rdy;
  // A sof pixel is forced to (0,0), so it can never produce a window.
  assign col_eff = pix_sof ? '0 : col;
  assign row_eff = pix_sof ? '0 : row;
  assign win_hit = (row_eff >= RW'(2)) && (col_eff >= CW'(2));
  assign top     = line2[col_eff];
  assign mid     = line1[col_eff];

  always_comb begin
    col_nxt = col_eff + 1'b1;
    row_nxt = row_eff;
    if (col_eff == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    case (state)
      IDLE: begin
        if (accept && win_hit && (WIN_GAP > 1)) begin
          state_nxt   = GAP;
          gap_cnt_nxt = GAP_LOAD;
        end
      end
      GAP: begin
        gap_cnt_nxt = gap_cnt - 1'b1;
        if (gap_cnt == GW'(1)) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      pix_rdy      <= 1'b0;
      col          <= '0;
      row          <= '0;
      win_gen_flag <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win[i]  <= '0;
        dout[i] <= '0;
      end
    end else begin
      state        <= state_nxt;
      gap_cnt      <= gap_cnt_nxt;
      pix_rdy      <= (state_nxt == IDLE);
      win_gen_flag <= accept && win_hit;
      if (accept) begin
        col <= col_nxt;
        row <= row_nxt;
        for (int i = 0; i < 3; i++) begin
          win[3*i]   <= win[3*i+1];
          win[3*i+1] <= win[3*i+2];
        end
        win[2] <= top;
        win[5] <= mid;
        win[8] <= pix_data;
        // Output copy includes the column arriving this cycle.
        if (win_hit) begin
          for (int i = 0; i < 3; i++) begin
            dout[3*i]   <= win[3*i+1];
            dout[3*i+1] <= win[3*i+2];
          end
          dout[2] <= top;
          dout[5] <= mid;
          dout[8] <= pix_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      line2[col_eff] <= mid;
      line1[col_eff] <= pix_data;
    end
  end

`ifdef MEDIAN_WINGEN_FRAME_DONE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= accept && win_hit && (row_eff == ROW_LAST) && (col_eff == COL_LAST);
  end
`endif

  assign data_in0 = dout[0];
  assign data_in1 = dout[1];
  assign data_in2 = dout[2];
  assign data_in3 = dout[3];
  assign data_in4 = dout[4];
  assign data_in5 = dout[5];
  assign data_in6 = dout[6];
  assign data_in7 = dout[7];
  assign data_in8 = dout[8];

endmodule

// File: tb/tb_median_window_gen.sv
// Bench for median_window_gen: frame-array reference model, spot-check table, pacing, sof and reset sequences.
module tb_median_window_gen;
  localparam int DW = 16, W = 8, H = 6, GAP = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, pix_vld, pix_sof, pix_rdy, win_gen_flag;
  logic [DW-1:0] pix_data, d0, d1, d2, d3, d4, d5, d6, d7, d8;
  logic [DW-1:0] dv [9];
  logic g1_vld, g1_sof, g1_rdy, g1_flag;
  logic [DW-1:0] g1_data, g1_d0, g1_d1, g1_d2, g1_d3, g1_d4, g1_d5, g1_d6, g1_d7, g1_d8;
`ifdef MEDIAN_WINGEN_FRAME_DONE_EN
  logic frame_done, g1_frame_done;
`endif

  median_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .WIN_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .pix_vld(pix_vld), .pix_sof(pix_sof), .pix_data(pix_data),
    .pix_rdy(pix_rdy), .win_gen_flag(win_gen_flag),
    .data_in0(d0), .data_in1(d1), .data_in2(d2), .data_in3(d3), .data_in4(d4),
    .data_in5(d5), .data_in6(d6), .data_in7(d7), .data_in8(d8)
`ifdef MEDIAN_WINGEN_FRAME_DONE_EN
    , .frame_done(frame_done)
`endif
  );

  median_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .WIN_GAP(1)) dut_g1 (
    .clk(clk), .rst_n(rst_n), .pix_vld(g1_vld), .pix_sof(g1_sof), .pix_data(g1_data),
    .pix_rdy(g1_rdy), .win_gen_flag(g1_flag),
    .data_in0(g1_d0), .data_in1(g1_d1), .data_in2(g1_d2), .data_in3(g1_d3), .data_in4(g1_d4),
    .data_in5(g1_d5), .data_in6(g1_d6), .data_in7(g1_d7), .data_in8(g1_d8)
`ifdef MEDIAN_WINGEN_FRAME_DONE_EN
    , .frame_done(g1_frame_done)
`endif
  );

  always_comb begin
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3; dv[4] = d4;
    dv[5] = d5; dv[6] = d6; dv[7] = d7; dv[8] = d8;
  end

  int tests = 0, fails = 0;

  // Reference model: the frame as a 2-D array, windows read straight out of it.
  logic [DW-1:0] img [H][W];
  logic [DW-1:0] exp_win [9];
  int mr, mc, block, flag_cnt, fd_cnt;
  logic          cap_flag [H][W];
  logic [DW-1:0] cap_d0 [H][W];
  logic [DW-1:0] cap_d4 [H][W];
  logic [DW-1:0] cap_d8 [H][W];

  typedef struct {
    int r; int c; logic f; logic [DW-1:0] e0; logic [DW-1:0] e4; logic [DW-1:0] e8;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mr = 0; mc = 0; block = 0;
    for (int k = 0; k < 9; k++) exp_win[k] = '0;
  endtask

  task automatic send(input logic [DW-1:0] dat, input logic sof);
    logic ef;
    pix_vld = 1'b1; pix_sof = sof; pix_data = dat;
    while (block > 0) begin
      chk($sformatf("stall_rdy@%0d,%0d", mr, mc), pix_rdy, 0);
      @(posedge clk); #1;
      block--;
      chk($sformatf("stall_flag@%0d,%0d", mr, mc), win_gen_flag, 0);
    end
    chk($sformatf("rdy@%0d,%0d", mr, mc), pix_rdy, 1);
    for (int k = 0; k < 20 && pix_rdy !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    if (pix_rdy !== 1'b1) begin
      fails++;
      $display("FAIL rdy_timeout: pix_rdy=%b required 1", pix_rdy);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "pix_rdy never returned");
    end
    @(posedge clk); #1;
    if (sof) begin mr = 0; mc = 0; end
    img[mr][mc] = dat;
    ef = (mr >= 2) && (mc >= 2);
    if (ef)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          exp_win[i*3+j] = img[mr-2+i][mc-2+j];
    chk($sformatf("flag@%0d,%0d", mr, mc), win_gen_flag, ef);
    for (int k = 0; k < 9; k++)
      chk($sformatf("d%0d@%0d,%0d", k, mr, mc), dv[k], exp_win[k]);
`ifdef MEDIAN_WINGEN_FRAME_DONE_EN
    chk($sformatf("frame_done@%0d,%0d", mr, mc), frame_done, ef && mr == H-1 && mc == W-1);
    if (frame_done === 1'b1) fd_cnt++;
`endif
    cap_flag[mr][mc] = win_gen_flag;
    cap_d0[mr][mc] = d0; cap_d4[mr][mc] = d4; cap_d8[mr][mc] = d8;
    if (win_gen_flag === 1'b1) flag_cnt++;
    block = ef ? GAP-1 : 0;
    mc++;
    if (mc == W) begin mc = 0; mr = (mr == H-1) ? 0 : mr + 1; end
    pix_vld = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    pix_vld = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (block > 0) block--;
      chk("idle_rdy", pix_rdy, block == 0);
    end
  endtask

  task automatic basic_frame(input string tag);
    flag_cnt = 0; fd_cnt = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(DW'(r*16 + c), r == 0 && c == 0);
    chk({tag, "_flag_count"}, flag_cnt, 24);
`ifdef MEDIAN_WINGEN_FRAME_DONE_EN
    chk({tag, "_frame_done_count"}, fd_cnt, 1);
`endif
    foreach (tbl[t]) begin
      chk($sformatf("%s_tbl_flag@%0d,%0d", tag, tbl[t].r, tbl[t].c), cap_flag[tbl[t].r][tbl[t].c], tbl[t].f);
      if (tbl[t].f) begin
        chk($sformatf("%s_tbl_d0@%0d,%0d", tag, tbl[t].r, tbl[t].c), cap_d0[tbl[t].r][tbl[t].c], tbl[t].e0);
        chk($sformatf("%s_tbl_d4@%0d,%0d", tag, tbl[t].r, tbl[t].c), cap_d4[tbl[t].r][tbl[t].c], tbl[t].e4);
        chk($sformatf("%s_tbl_d8@%0d,%0d", tag, tbl[t].r, tbl[t].c), cap_d8[tbl[t].r][tbl[t].c], tbl[t].e8);
      end
    end
  endtask

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int pre;
    tbl[0] = '{2, 2, 1'b1, 16'h00, 16'h11, 16'h22};
    tbl[1] = '{5, 7, 1'b1, 16'h35, 16'h46, 16'h57};
    tbl[2] = '{3, 0, 1'b0, 16'h00, 16'h00, 16'h00};
    tbl[3] = '{3, 1, 1'b0, 16'h00, 16'h00, 16'h00};
    tbl[4] = '{3, 2, 1'b1, 16'h10, 16'h21, 16'h32};
    tbl[5] = '{4, 5, 1'b1, 16'h23, 16'h34, 16'h45};

    rst_n = 1'b0; pix_vld = 1'b0; pix_sof = 1'b0; pix_data = '0;
    g1_vld = 1'b0; g1_sof = 1'b0; g1_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdy", pix_rdy, 0);
    chk("reset_flag", win_gen_flag, 0);
    for (int k = 0; k < 9; k++) chk($sformatf("reset_d%0d", k), dv[k], 0);
`ifdef MEDIAN_WINGEN_FRAME_DONE_EN
    chk("reset_frame_done", frame_done, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_reset", pix_rdy, 1);

    // WIN_GAP=1 instance: never stalls, interior flags on consecutive cycles.
    g1_vld = 1'b1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        g1_sof = (r == 0 && c == 0);
        g1_data = DW'(r*16 + c);
        chk($sformatf("g1_rdy@%0d,%0d", r, c), g1_rdy, 1);
        @(posedge clk); #1;
        chk($sformatf("g1_flag@%0d,%0d", r, c), g1_flag, (r >= 2 && c >= 2));
        if (r >= 2 && c >= 2)
          chk($sformatf("g1_d4@%0d,%0d", r, c), g1_d4, (r-1)*16 + (c-1));
      end
    g1_vld = 1'b0; g1_sof = 1'b0;

    basic_frame("basic");

    // Mid-frame sof on the 20th pixel; restarted frame uses distinct values.
    for (int i = 0; i < 19; i++) send(DW'((i / W)*16 + (i % W)), i == 0);
    flag_cnt = 0; fd_cnt = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r == 2 && c == 0) chk("sof_no_flag_two_rows", flag_cnt, 0);
        send(DW'(16'h80 + r*16 + c), r == 0 && c == 0);
      end
    chk("sof_flag_count", flag_cnt, 24);
`ifdef MEDIAN_WINGEN_FRAME_DONE_EN
    chk("sof_frame_done_count", fd_cnt, 1);
`endif

    // Reset for one cycle at pixel (4,3), then a clean frame.
    pre = 4*W + 3;
    for (int i = 0; i < pre; i++) send(DW'((i / W)*16 + (i % W)), i == 0);
    idle(GAP);
    pix_vld = 1'b1; pix_data = 16'h43; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_rdy", pix_rdy, 0);
    chk("midrst_flag", win_gen_flag, 0);
    for (int k = 0; k < 9; k++) chk($sformatf("midrst_d%0d", k), dv[k], 0);
`ifdef MEDIAN_WINGEN_FRAME_DONE_EN
    chk("midrst_frame_done", frame_done, 0);
`endif
    rst_n = 1'b1; pix_vld = 1'b0;
    @(posedge clk); #1;
    chk("midrst_rdy_back", pix_rdy, 1);
    model_reset();
    basic_frame("after_reset");

    // Random data, random idle gaps and occasional stray sof.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(3) == 0) idle($urandom_range(6, 1));
      send(DW'($urandom), (i == 0) || ($urandom_range(59) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
